font_fetch_ctrl: RTL and testbench

FONT_FETCH_CTRL -- requirements
Module: font_fetch_ctrl

---
 rtl/gfx_pkg.sv | 9 +
 rtl/glyph_fifo.sv | 41 ++++
 rtl/font_fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_font_fetch_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared glyph/font constants and fetch FSM state type
package gfx_pkg;
  localparam int GLYPH_W     = 8;
  localparam int FONT_ROWS   = 16;
  localparam int FONT_ADDR_W = 12;
  localparam int TXT_ADDR_W  = 11;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;
endpackage

// File: rtl/glyph_fifo.sv
// rtl/glyph_fifo.sv - small first-word-fall-through buffer of glyph bytes with occupancy count
module glyph_fifo
  import gfx_pkg::*;
#(
  parameter int DEPTH = 2
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [GLYPH_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [GLYPH_W-1:0] rd_data,
  output logic [2:0]         count
);
  localparam int              PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [GLYPH_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               do_wr, do_rd;

  assign do_rd   = rd_en && (count != 3'd0);
  assign do_wr   = wr_en && (count != 3'(DEPTH));
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
      count <= count + {2'b00, do_wr} - {2'b00, do_rd};
    end
  end
endmodule

// File: rtl/font_fetch_ctrl.sv
// rtl/font_fetch_ctrl.sv - fetches one text line of glyph rows and streams pixels MSB first
// Build option FONT_FETCH_CURSOR_EN inverts the glyph bytes of the cursor cell.
module font_fetch_ctrl
  import gfx_pkg::*;
#(
  parameter int COLS       = 80,
  parameter int FIFO_DEPTH = 2
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          line_start,
  input  logic [TXT_ADDR_W-1:0]         base_addr,
  input  logic [$clog2(FONT_ROWS)-1:0]  cell_row,
  output logic                          txt_rd,
  output logic [TXT_ADDR_W-1:0]         txt_addr,
  input  logic [GLYPH_W-1:0]            txt_data,
  output logic                          rom_enable,
  output logic                          rom_next,
  output logic [FONT_ADDR_W-1:0]        rom_next_addr,
  input  logic [GLYPH_W-1:0]            rom_data,
  output logic                          pix_out,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic                          busy,
  output logic                          line_done,
  input  logic [6:0]                    cursor_col,
  input  logic                          cursor_on
);
  localparam int         ROW_W    = $clog2(FONT_ROWS);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);

  fetch_state_t          state, state_nxt;
  logic [TXT_ADDR_W-1:0] base_q;
  logic [ROW_W-1:0]      row_q;
  logic [6:0]            col;
  logic                  rd_d1, rd_d2, rd_d3;
  logic [1:0]            in_flight;
  logic [2:0]            fifo_count;
  logic [GLYPH_W-1:0]    fifo_dout, wr_byte, sh_data;
  logic [3:0]            sh_cnt;
  logic                  hs, load, last_hs, credit_ok, line_done_q;

  // rd_d1..rd_d3 track each text read until its ROM byte lands in the FIFO
  assign in_flight = 2'(rd_d1) + 2'(rd_d2) + 2'(rd_d3);
  assign credit_ok = (4'(fifo_count) + 4'(in_flight)) < 4'(FIFO_DEPTH);

  assign pix_valid = (sh_cnt != 4'd0);
  assign pix_out   = pix_valid && sh_data[GLYPH_W-1];
  assign hs        = pix_valid && pix_ready;
  assign load      = (fifo_count != 3'd0) && ((sh_cnt == 4'd0) || (sh_cnt == 4'd1 && hs));
  assign last_hs   = hs && (sh_cnt == 4'd1) && (fifo_count == 3'd0) && (in_flight == 2'd0);

  assign busy          = (state != IDLE);
  assign rom_next      = busy;
  assign rom_enable    = rd_d1;
  assign rom_next_addr = rd_d1 ? {txt_data, row_q} : '0;
  assign txt_addr      = txt_rd ? base_q + TXT_ADDR_W'(col) : '0;
  assign line_done     = line_done_q;

  always_comb begin
    state_nxt = state;
    txt_rd    = 1'b0;
    case (state)
      IDLE:  if (line_start) state_nxt = FETCH;
      FETCH: begin
        txt_rd = credit_ok;
        if (credit_ok && col == LAST_COL) state_nxt = DRAIN;
      end
      DRAIN: if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      base_q      <= '0;
      row_q       <= '0;
      col         <= '0;
      rd_d1       <= 1'b0;
      rd_d2       <= 1'b0;
      rd_d3       <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd_d1       <= txt_rd;
      rd_d2       <= rd_d1;
      rd_d3       <= rd_d2;
      line_done_q <= (state == DRAIN) && last_hs;
      if (state == IDLE && line_start) begin
        base_q <= base_addr;
        row_q  <= cell_row;
        col    <= '0;
      end else if (txt_rd) begin
        col <= col + 7'd1;
      end
    end
  end

  // Reload on the 8th handshake keeps the stream gapless across glyph bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_data <= '0;
      sh_cnt  <= '0;
    end else if (load) begin
      sh_data <= fifo_dout;
      sh_cnt  <= 4'(GLYPH_W);
    end else if (hs) begin
      sh_data <= {sh_data[GLYPH_W-2:0], 1'b0};
      sh_cnt  <= sh_cnt - 4'd1;
    end
  end

`ifdef FONT_FETCH_CURSOR_EN
  logic [6:0] cur_col_q, col_d1, col_d2, col_d3;
  logic       cur_on_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_col_q <= '0;
      cur_on_q  <= 1'b0;
      col_d1    <= '0;
      col_d2    <= '0;
      col_d3    <= '0;
    end else begin
      col_d1 <= col;
      col_d2 <= col_d1;
      col_d3 <= col_d2;
      if (state == IDLE && line_start) begin
        cur_col_q <= cursor_col;
        cur_on_q  <= cursor_on;
      end
    end
  end

  assign wr_byte = (cur_on_q && col_d3 == cur_col_q) ? ~rom_data : rom_data;
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_col, cursor_on};
  assign wr_byte       = rom_data;
`endif

  glyph_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rd_d3),
    .wr_data (wr_byte),
    .rd_en   (load),
    .rd_data (fifo_dout),
    .count   (fifo_count)
  );
endmodule

// File: tb/tb_font_fetch_ctrl.sv
// tb/tb_font_fetch_ctrl.sv - randomized self-checking bench for font_fetch_ctrl
`timescale 1ns/1ps
module tb_font_fetch_ctrl;
  localparam int COLS       = 80;
  localparam int FIFO_DEPTH = 2;
`ifdef FONT_FETCH_CURSOR_EN
  localparam bit CURSOR_BUILD = 1'b1;
`else
  localparam bit CURSOR_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_start = 1'b0;
  logic [10:0] base_addr = '0;
  logic [3:0]  cell_row = '0;
  logic        txt_rd;
  logic [10:0] txt_addr;
  logic [7:0]  txt_data = '0;
  logic        rom_enable, rom_next;
  logic [11:0] rom_next_addr;
  logic [7:0]  rom_data = '0;
  logic        pix_out, pix_valid;
  logic        pix_ready = 1'b1;
  logic        busy, line_done;
  logic [6:0]  cursor_col = '0;
  logic        cursor_on = 1'b0;

  font_fetch_ctrl #(.COLS(COLS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .base_addr(base_addr),
    .cell_row(cell_row), .txt_rd(txt_rd), .txt_addr(txt_addr), .txt_data(txt_data),
    .rom_enable(rom_enable), .rom_next(rom_next), .rom_next_addr(rom_next_addr),
    .rom_data(rom_data), .pix_out(pix_out), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .busy(busy), .line_done(line_done),
    .cursor_col(cursor_col), .cursor_on(cursor_on)
  );

  always #5 clk = ~clk;

  logic [7:0] txt_mem [2048];
  logic [7:0] rom_mem [4096];
  logic [7:0] rom_p1;

  // memories: text data 1 cycle after read, ROM data 2 cycles after enable
  always @(posedge clk) begin
    txt_data <= txt_mem[txt_addr];
    rom_p1   <= rom_mem[rom_next_addr];
    rom_data <= rom_p1;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [10:0] addr_q [$];
  logic [11:0] radr_q [$];
  bit          pix_q  [$];

  bit rnd_ready = 1'b0;
  bit all_ready = 1'b1;
  bit in_line = 1'b0, pv_seen = 1'b0, stall = 1'b0, stall_val = 1'b0;
  int line_l = 0, pix_cnt = 0, last_pix_cyc = 0, done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_model(input logic [10:0] base, input logic [3:0] row,
                             input logic [6:0] ccol, input bit con);
    for (int c = 0; c < COLS; c++) begin
      logic [10:0] a;
      logic [11:0] ra;
      logic [7:0]  g;
      a  = base + 11'(c);
      ra = {txt_mem[a], row};
      g  = rom_mem[ra];
      if (CURSOR_BUILD && con && int'(ccol) == c) g = ~g;
      addr_q.push_back(a);
      radr_q.push_back(ra);
      for (int b = 7; b >= 0; b--) pix_q.push_back(g[b]);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", 32'(busy), 0);
    check("rst_line_done", 32'(line_done), 0);
    check("rst_txt_rd", 32'(txt_rd), 0);
    check("rst_rom_enable", 32'(rom_enable), 0);
    check("rst_rom_next", 32'(rom_next), 0);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_pix_out", 32'(pix_out), 0);
    check("rst_txt_addr", 32'(txt_addr), 0);
    check("rst_rom_next_addr", 32'(rom_next_addr), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      in_line = 1'b0;
      pix_cnt = 0;
      stall   = 1'b0;
    end else begin
      if (line_start && !in_line) begin
        in_line = 1'b1; line_l = cyc; pix_cnt = 0; pv_seen = 1'b0;
      end
      if (txt_rd) begin
        if (addr_q.size() == COLS) check("lat_txt_rd", cyc - line_l, 1);
        check("txt_rd_pending", 32'(addr_q.size() != 0), 1);
        if (addr_q.size() != 0) check("txt_addr", 32'(txt_addr), 32'(addr_q.pop_front()));
        check("rom_next", 32'(rom_next), 1);
      end
      if (rom_enable) begin
        if (radr_q.size() == COLS) check("lat_rom_enable", cyc - line_l, 2);
        check("rom_pending", 32'(radr_q.size() != 0), 1);
        if (radr_q.size() != 0) check("rom_next_addr", 32'(rom_next_addr), 32'(radr_q.pop_front()));
      end
      if (pix_valid && in_line && !pv_seen) begin
        check("lat_pix_valid", cyc - line_l, 6);
        pv_seen = 1'b1;
      end
      if (stall) begin
        check("hold_valid", 32'(pix_valid), 1);
        check("hold_pix", 32'(pix_out), 32'(stall_val));
      end
      if (pix_valid && pix_ready) begin
        check("pix_pending", 32'(pix_q.size() != 0), 1);
        if (pix_q.size() != 0) check("pix", 32'(pix_out), 32'(pix_q.pop_front()));
        if (all_ready && pix_cnt > 0) check("pix_gap", cyc - last_pix_cyc, 1);
        pix_cnt++;
        last_pix_cyc = cyc;
      end
      stall     = pix_valid && !pix_ready;
      stall_val = pix_out;
      if (line_done) begin
        check("done_lat", cyc - last_pix_cyc, 1);
        check("line_len", pix_cnt, 8 * COLS);
        check("busy_at_done", 32'(busy), 0);
        check("queues_empty", pix_q.size() + addr_q.size() + radr_q.size(), 0);
        in_line = 1'b0;
        done_cnt++;
      end
    end
  end

  task automatic run_line(input logic [10:0] base, input logic [3:0] row, input logic [6:0] ccol,
                          input bit con, input bit rnd, input bit inject, input bit abort);
    int d0, n;
    all_ready = !rnd;
    rnd_ready = rnd;
    build_model(base, row, ccol, con);
    @(posedge clk); #1;
    base_addr = base; cell_row = row; cursor_col = ccol; cursor_on = con;
    line_start = 1'b1;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 6000 && !(abort && pix_cnt >= 100)) begin
      @(posedge clk); #1;
      n++;
      if (inject && n == 40) begin
        line_start = 1'b1;
        base_addr  = 11'($urandom);
        cell_row   = 4'($urandom);
        cursor_on  = ~con;
      end else begin
        line_start = 1'b0;
      end
    end
    line_start = 1'b0;
    if (abort) begin
      check("abort_reached", 32'(pix_cnt >= 100), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      addr_q.delete(); radr_q.delete(); pix_q.delete();
      @(negedge clk);
      check_reset_outputs();
      repeat (30) @(posedge clk);
      check("no_line_done", done_cnt, d0);
    end else begin
      check("line_finished", 32'(done_cnt != d0), 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) txt_mem[i] = 8'($urandom);
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom);
    txt_mem[11'h7FE] = 8'h41;
    txt_mem[11'h7FF] = 8'h42;
    txt_mem[11'h000] = 8'h43;
    txt_mem[11'h001] = 8'h44;
    rom_mem[12'h415] = 8'hC6;
    txt_mem[11'h102] = 8'h30;
    rom_mem[12'h309] = 8'h18;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    run_line(11'h7FE, 4'd5, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_line(11'h100, 4'd9, 7'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      run_line(11'($urandom), 4'($urandom), 7'($urandom_range(0, COLS - 1)),
               1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
    run_line(11'($urandom), 4'($urandom), 7'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_line(11'($urandom), 4'($urandom), 7'd5, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
